// File: rtl/opcode_issuer.sv
// opcode_issuer: buffers {op,count} commands in a FIFO and emits each op count times on a valid/ready stream.
module opcode_issuer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [CNT_W-1:0] in_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_opcode,
  output logic             err,
  output logic             busy
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t            r_state;
  logic [CNT_W+1:0]  r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_occ;
  logic [CNT_W-1:0]  r_rem;
  logic [4:0]        r_opcode;
  logic              r_err;
  logic              w_full;
  logic              w_empty;
  logic              w_acc;
  logic              w_push;
  logic              w_pop;
  logic              w_hs;
  logic              w_last;
  logic [CNT_W+1:0]  w_head;
  assign w_full     = r_occ == (AW+1)'(DEPTH);
  assign w_empty    = r_occ == '0;
  assign in_ready   = !w_full && !reset;
  assign w_acc      = in_valid && in_ready;
  assign w_push     = w_acc && in_op != 2'd3 && in_count != '0;
  assign w_hs       = r_state == ISSUE && out_ready;
  assign w_last     = r_rem == CNT_W'(1);
  // Reload from the FIFO either when idle or on the final beat, so consecutive commands stream without a gap
  assign w_pop      = !w_empty && (r_state == IDLE || (w_hs && w_last));
  assign w_head     = r_mem[r_rd_ptr];
  assign out_valid  = r_state == ISSUE;
  assign out_opcode = r_opcode;
  assign err        = r_err;
  assign busy       = !w_empty || r_state == ISSUE;
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= {in_op, in_count};
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_rem    <= '0;
      r_opcode <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_acc && in_op == 2'd3;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_occ <= r_occ + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
      if (w_pop) begin
        r_state  <= ISSUE;
        r_opcode <= {3'b000, w_head[CNT_W+1:CNT_W]};
        r_rem    <= w_head[CNT_W-1:0];
      end else if (w_hs) begin
        if (w_last) begin
          r_state  <= IDLE;
          r_opcode <= '0;
          r_rem    <= '0;
        end else begin
          r_rem <= r_rem - 1'b1;
        end
      end
    end
  end
endmodule
